// File: rtl/fir_lowpass_interpolator.sv
// Polyphase symmetric-FIR interpolator (x M) sharing one MAC; half-length coefficient RAM.
// Define FIR_INTERP_ROUND_EN to round half up before saturation instead of truncating.
module fir_lowpass_interpolator #(
    parameter int ORD         = 255,
    parameter int M           = 8,
    parameter int D           = 100,
    parameter int COEFF_SIZE  = 16,
    parameter int SAMPLE_SIZE = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SAMPLE_SIZE-1:0]     din,
    output logic [SAMPLE_SIZE-1:0]     dout,
    input  logic                       c_we,
    input  logic [COEFF_SIZE-1:0]      c_in,
    input  logic [$clog2(ORD+1)-1:0]   c_addr
);
    localparam int TAPS   = ORD + 1;
    localparam int HALF   = TAPS / 2;
    localparam int T      = TAPS / M;
    localparam int KW     = $clog2(TAPS);
    localparam int HW     = $clog2(HALF);
    localparam int TW     = $clog2(T);
    localparam int DW     = $clog2(D);
    localparam int PW     = (M > 1) ? $clog2(M) : 1;
    localparam int PROD_W = COEFF_SIZE + SAMPLE_SIZE;
    localparam int AW     = PROD_W + TW;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(2**(SAMPLE_SIZE-1) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2**(SAMPLE_SIZE-1)));

    logic [COEFF_SIZE-1:0]   coeff_mem [HALF];
    logic [DW-1:0]           div_cnt_q, div_cnt_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic [SAMPLE_SIZE-1:0]  x_q [T];
    logic [SAMPLE_SIZE-1:0]  x_d [T];
    logic [COEFF_SIZE-1:0]   mac_c_q, mac_c_d;
    logic [SAMPLE_SIZE-1:0]  mac_x_q, mac_x_d;
    logic [AW-1:0]           acc_q, acc_d;
    logic [SAMPLE_SIZE-1:0]  dout_q, dout_d;

    logic [TW-1:0]           tap_j;
    logic [KW-1:0]           tap_k;
    logic [HW-1:0]           coeff_addr;
    logic signed [PROD_W-1:0] prod;
    logic signed [AW-1:0]    acc_r;
    logic signed [AW-1:0]    shifted;
    logic [SAMPLE_SIZE-1:0]  sat_val;

    assign dout = dout_q;

    // Upper half of the symmetric response is folded onto the stored half: h[k] = h[ORD-k].
    always_comb begin
        tap_j      = TW'(div_cnt_q - 1'b1);
        tap_k      = KW'(tap_j) * KW'(M) + KW'(phase_q);
        coeff_addr = (tap_k >= KW'(HALF)) ? HW'(KW'(ORD) - tap_k) : HW'(tap_k);
        prod       = PROD_W'($signed(mac_c_q)) * PROD_W'($signed(mac_x_q));
`ifdef FIR_INTERP_ROUND_EN
        acc_r      = $signed(acc_q) + (AW'(1) <<< (COEFF_SIZE - 2));
`else
        acc_r      = $signed(acc_q);
`endif
        shifted    = acc_r >>> (COEFF_SIZE - 1);
        if (shifted > SAT_MAX)
            sat_val = {1'b0, {(SAMPLE_SIZE-1){1'b1}}};
        else if (shifted < SAT_MIN)
            sat_val = {1'b1, {(SAMPLE_SIZE-1){1'b0}}};
        else
            sat_val = shifted[SAMPLE_SIZE-1:0];
    end

    // Pipeline: operand fetch at div_cnt 1..T, accumulate at 2..T+1, dout loads at T+2 (visible at T+3).
    always_comb begin
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        x_d       = x_q;
        mac_c_d   = mac_c_q;
        mac_x_d   = mac_x_q;
        acc_d     = acc_q;
        dout_d    = dout_q;
        if (c_we) begin
            div_cnt_d = '0;
            phase_d   = '0;
        end else begin
            if (div_cnt_q == DW'(D - 1)) begin
                div_cnt_d = '0;
                phase_d   = (phase_q == PW'(M - 1)) ? '0 : phase_q + 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
            if (div_cnt_q == '0 && phase_q == '0) begin
                x_d[0] = din;
                for (int unsigned j = 1; j < T; j++)
                    x_d[j] = x_q[j-1];
            end
            if (div_cnt_q >= DW'(1) && div_cnt_q <= DW'(T)) begin
                mac_c_d = coeff_mem[coeff_addr];
                mac_x_d = x_q[tap_j];
            end
            if (div_cnt_q <= DW'(1))
                acc_d = '0;
            else if (div_cnt_q <= DW'(T + 1))
                acc_d = acc_q + {{TW{prod[PROD_W-1]}}, prod};
            if (div_cnt_q == DW'(T + 2))
                dout_d = sat_val;
        end
    end

    always_ff @(posedge clk) begin
        if (c_we && c_addr < KW'(HALF))
            coeff_mem[c_addr[HW-1:0]] <= c_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            phase_q   <= '0;
            x_q       <= '{default: '0};
            mac_c_q   <= '0;
            mac_x_q   <= '0;
            acc_q     <= '0;
            dout_q    <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            x_q       <= x_d;
            mac_c_q   <= mac_c_d;
            mac_x_q   <= mac_x_d;
            acc_q     <= acc_d;
            dout_q    <= dout_d;
        end
    end
endmodule

// File: tb/tb_fir_lowpass_interpolator.sv
// Directed bench for fir_lowpass_interpolator with a queue scoreboard fed by a reference model.
module tb_fir_lowpass_interpolator;
    localparam int ORD  = 255;
    localparam int M    = 8;
    localparam int D    = 100;
    localparam int T    = (ORD + 1) / M;
    localparam int HALF = (ORD + 1) / 2;
`ifdef FIR_INTERP_ROUND_EN
    localparam logic [15:0] IMP_EXP = 16'h4000;
`else
    localparam logic [15:0] IMP_EXP = 16'h3FFF;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [15:0] dout;
    logic        c_we;
    logic [15:0] c_in;
    logic [7:0]  c_addr;

    int n_pass = 0;
    int n_chk  = 0;
    logic [15:0]        sb_q [$];
    logic signed [15:0] hm [HALF];
    logic signed [15:0] xm [T];
    int                 m_phase;
    logic [15:0]        last_exp;

    fir_lowpass_interpolator #(
        .ORD(ORD), .M(M), .D(D), .COEFF_SIZE(16), .SAMPLE_SIZE(16)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout),
        .c_we(c_we), .c_in(c_in), .c_addr(c_addr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: dout=0x%h expected 0x%h", tag, obs, exp);
    endtask

    function automatic logic [15:0] model_out(input int ph);
        longint acc = 0;
        longint s;
        int     k;
        for (int j = 0; j < T; j++) begin
            k = j * M + ph;
            acc += longint'(hm[(k < HALF) ? k : ORD - k]) * longint'(xm[j]);
        end
`ifdef FIR_INTERP_ROUND_EN
        acc += longint'(1) << 14;
`endif
        s = acc >>> 15;
        if (s > 32767)       return 16'h7FFF;
        else if (s < -32768) return 16'h8000;
        else                 return s[15:0];
    endfunction

    task automatic model_shift(input logic [15:0] v);
        for (int j = T - 1; j > 0; j--) xm[j] = xm[j-1];
        xm[0] = v;
    endtask

    task automatic model_clear();
        for (int j = 0; j < T; j++) xm[j] = '0;
        m_phase  = 0;
        last_exp = '0;
    endtask

    // Ends with c_we low so the next slot starts on the very next cycle.
    task automatic load(input logic [15:0] v0, input logic [15:0] vrest);
        for (int a = 0; a < HALF; a++) begin
            c_we   = 1'b1;
            c_addr = 8'(a);
            c_in   = (a == 0) ? v0 : vrest;
            hm[a]  = (a == 0) ? v0 : vrest;
            tick(1);
        end
        c_addr = 8'd200;
        c_in   = 16'h5555;
        tick(1);
        check("load_hold", dout, last_exp);
        c_we    = 1'b0;
        m_phase = 0;
    endtask

    task automatic slot(input logic [15:0] v);
        logic [15:0] e;
        if (m_phase == 0) begin
            din = v;
            model_shift(v);
        end
        sb_q.push_back(model_out(m_phase));
        tick(T + 2);
        check("pre_update_hold", dout, last_exp);
        tick(1);
        e = sb_q.pop_front();
        check("slot_out", dout, e);
        last_exp = e;
        tick(D - T - 3);
        m_phase = (m_phase + 1) % M;
    endtask

    task automatic input_sample(input logic [15:0] v);
        for (int p = 0; p < M; p++) slot(v);
    endtask

    initial begin
        rst = 1'b1; c_we = 1'b0; c_in = '0; c_addr = '0; din = '0;
        model_clear();
        tick(3);
        rst = 1'b0;
        check("reset_dout", dout, 16'h0000);

        // Impulse through h[0] and its mirror h[255]
        load(16'h7FFF, 16'h0000);
        input_sample(16'h4000);
        check("impulse_phase7_zero", dout, 16'h0000);
        for (int i = 1; i < T; i++) input_sample(16'h0000);
        check("impulse_mirror", dout, IMP_EXP);

        // DC response once the delay line is full
        load(16'h0200, 16'h0200);
        for (int i = 0; i < T; i++) input_sample(16'h4000);
        check("dc_steady", dout, 16'h2000);

        // c_we raised mid-slot: slot aborted, dout holds, addr 200 write ignored
        tick(20);
        model_shift(din);
        c_we = 1'b1; c_addr = 8'd200; c_in = 16'h5555;
        tick(5);
        check("we_abort_hold", dout, last_exp);
        c_we = 1'b0;
        m_phase = 0;
        input_sample(16'h4000);
        check("dc_after_abort", dout, 16'h2000);

        // Reset mid-slot clears dout and delay line, schedule restarts at phase 0
        tick(20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_mid_slot", dout, 16'h0000);
        model_clear();
        slot(16'h4000);
        check("restart_first", dout, 16'h0100);

        // Saturation, both signs
        load(16'h7FFF, 16'h7FFF);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_clear();
        input_sample(16'h7FFF);
        input_sample(16'h7FFF);
        check("sat_pos", dout, 16'h7FFF);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        model_clear();
        input_sample(16'h8000);
        input_sample(16'h8000);
        check("sat_neg", dout, 16'h8000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
